// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC plane scheduling logic.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } sched_state_e;

  localparam int MAX_VC = 32;

  // First set bit of req[n-1:0] scanning cyclically from ptr+1; ptr itself is
  // visited last. Returns -1 when nothing is requesting.
  function automatic int rr_first(input logic [MAX_VC-1:0] req, input int n, input int ptr);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = MAX_VC + 1;
    for (int i = 0; i < MAX_VC; i++) begin
      if (i < n && req[i]) begin
        d = (i > ptr) ? (i - ptr) : (i - ptr + n);
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/vc_plane_scheduler_rr_pick.sv
// Combinational round-robin picker: request vector plus pointer give a one-hot
// grant and its binary index.
module rr_pick
  import noc_pkg::*;
#(
  parameter int VC    = 4,
  parameter int IDX_W = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic [VC-1:0]    req,
  input  logic [IDX_W-1:0] ptr,
  output logic [VC-1:0]    gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_VC-1:0] req_w;
  int                win;

  always_comb begin
    req_w          = '0;
    req_w[VC-1:0]  = req;
    win            = rr_first(req_w, VC, int'(ptr));
    any            = (win >= 0);
    gnt            = '0;
    idx            = '0;
    for (int i = 0; i < VC; i++) begin
      gnt[i] = (win == i);
    end
    if (win >= 0) begin
      idx = IDX_W'(win);
    end
  end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Time-slot scheduler granting the shared switch/output bus to one VC plane
// at a time: demand-aware round robin with quantum, hold cap and guard gap.
module vc_plane_scheduler
  import noc_pkg::*;
#(
  parameter int VC           = 4,
  parameter int QUANTUM      = 8,
  parameter int HOLD_LIMIT   = 32,
  parameter int GUARD_CYCLES = 1,
  parameter int CNT_W        = $clog2(HOLD_LIMIT + 1),
  parameter int IDX_W        = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VC-1:0]    plane_req,
  input  logic [VC-1:0]    plane_hold,
  output logic [VC-1:0]    vc_sel,
  output logic             vc_sel_valid,
  output logic [IDX_W-1:0] vc_sel_idx,
  output logic             preempt_pulse
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       guard_cnt_q, guard_cnt_d;
  logic [VC-1:0]    sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;

  logic [VC-1:0]    gnt_all, gnt_excl;
  logic [IDX_W-1:0] idx_all, idx_excl;
  logic             any_all, any_excl;
  logic             g_req, g_hold, others, quantum_up, end_grant;

  rr_pick #(.VC(VC), .IDX_W(IDX_W)) u_pick_all (
    .req(plane_req), .ptr(rr_ptr_q), .gnt(gnt_all), .idx(idx_all), .any(any_all)
  );

  // In GRANT sel_q is the granted plane, so masking with it excludes g.
  rr_pick #(.VC(VC), .IDX_W(IDX_W)) u_pick_excl (
    .req(plane_req & ~sel_q), .ptr(rr_ptr_q), .gnt(gnt_excl), .idx(idx_excl), .any(any_excl)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    slot_cnt_d  = slot_cnt_q;
    guard_cnt_d = guard_cnt_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    preempt_d   = 1'b0;
    end_grant   = 1'b0;
    g_req       = |(plane_req & sel_q);
    g_hold      = |(plane_hold & sel_q);
    others      = |(plane_req & ~sel_q);
    quantum_up  = (slot_cnt_q >= CNT_W'(QUANTUM - 1));

    unique case (state_q)
      IDLE: begin
        if (any_all) begin
          state_d    = GRANT;
          rr_ptr_d   = idx_all;
          slot_cnt_d = '0;
          sel_d      = gnt_all;
          idx_d      = idx_all;
        end
      end
      GRANT: begin
        if (!g_req && !g_hold) begin
          end_grant = 1'b1;
        end else if (quantum_up && others && !g_hold) begin
          end_grant = 1'b1;
        end else if (slot_cnt_q == CNT_W'(HOLD_LIMIT - 1) && others) begin
          end_grant = 1'b1;
          preempt_d = 1'b1;
        end else if (quantum_up && !others) begin
          slot_cnt_d = '0;
        end else if (slot_cnt_q != CNT_W'(HOLD_LIMIT)) begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end

        if (end_grant) begin
          slot_cnt_d = '0;
          if (GUARD_CYCLES > 0) begin
            state_d     = GUARD;
            guard_cnt_d = '0;
            sel_d       = '0;
            idx_d       = '0;
          end else if (any_excl) begin
            rr_ptr_d = idx_excl;
            sel_d    = gnt_excl;
            idx_d    = idx_excl;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            idx_d   = '0;
          end
        end
      end
      GUARD: begin
        if (int'(guard_cnt_q) >= GUARD_CYCLES - 1) begin
          if (any_all) begin
            state_d    = GRANT;
            rr_ptr_d   = idx_all;
            slot_cnt_d = '0;
            sel_d      = gnt_all;
            idx_d      = idx_all;
          end else begin
            state_d = IDLE;
          end
        end else begin
          guard_cnt_d = guard_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |sel_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(VC - 1);
      slot_cnt_q  <= '0;
      guard_cnt_q <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      slot_cnt_q  <= slot_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign vc_sel        = sel_q;
  assign vc_sel_valid  = valid_q;
  assign vc_sel_idx    = idx_q;
  assign preempt_pulse = preempt_q;

endmodule
